// File: rtl/target_extent_tracker.sv
// Per-frame bounding-box tracker: collects min/max x/y of colour-matched pixels
// over one frame and publishes centre/size two cycles after frame_end.
module target_extent_tracker #(
    parameter int MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        frame_end,
    input  logic        pix_valid,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_match,
    output logic [10:0] t_x,
    output logic [9:0]  t_y,
    output logic [10:0] t_width,
    output logic [10:0] t_height,
    output logic        found,
    output logic        result_valid,
    output logic [1:0]  fsm_state
);

    // Handshake: there is no backpressure. Inputs are qualified by pix_valid /
    // the frame pulses alone; result_valid is a one-cycle pulse marking the
    // cycle in which t_x..found first show the new frame's result. Outputs
    // hold their value until the next pulse.

    localparam logic [15:0] MIN_COUNT = 16'(MIN_PIXELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        FINAL   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    state_t      state;

    logic [10:0] min_x, max_x;
    logic [9:0]  min_y, max_y;
    logic [15:0] count;

    logic [11:0] sum_x;
    logic [10:0] sum_y;
    logic [10:0] span_x;
    logic [9:0]  span_y;

    logic        hit;
    logic [10:0] base_min_x, base_max_x, nxt_min_x, nxt_max_x;
    logic [9:0]  base_min_y, base_max_y, nxt_min_y, nxt_max_y;
    logic [15:0] base_count, nxt_count;

    assign fsm_state = state;
    assign hit       = pix_valid & pix_match;

    // A frame_start pixel is folded into freshly seeded accumulators.
    always_comb begin
        base_min_x = min_x;
        base_max_x = max_x;
        base_min_y = min_y;
        base_max_y = max_y;
        base_count = count;
        if (frame_start) begin
            base_min_x = '1;
            base_max_x = '0;
            base_min_y = '1;
            base_max_y = '0;
            base_count = '0;
        end

        nxt_min_x = base_min_x;
        nxt_max_x = base_max_x;
        nxt_min_y = base_min_y;
        nxt_max_y = base_max_y;
        nxt_count = base_count;
        if (hit) begin
            if (pix_x < base_min_x) nxt_min_x = pix_x;
            if (pix_x > base_max_x) nxt_max_x = pix_x;
            if (pix_y < base_min_y) nxt_min_y = pix_y;
            if (pix_y > base_max_y) nxt_max_y = pix_y;
            if (base_count != 16'hFFFF) nxt_count = base_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            min_x        <= '1;
            max_x        <= '0;
            min_y        <= '1;
            max_y        <= '0;
            count        <= '0;
            sum_x        <= '0;
            sum_y        <= '0;
            span_x       <= '0;
            span_y       <= '0;
            t_x          <= '0;
            t_y          <= '0;
            t_width      <= '0;
            t_height     <= '0;
            found        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (frame_start) begin
                // Restart from any state; an unfinished frame is dropped silently.
                min_x <= nxt_min_x;
                max_x <= nxt_max_x;
                min_y <= nxt_min_y;
                max_y <= nxt_max_y;
                count <= nxt_count;
                state <= ACCUM;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ACCUM: begin
                        min_x <= nxt_min_x;
                        max_x <= nxt_max_x;
                        min_y <= nxt_min_y;
                        max_y <= nxt_max_y;
                        count <= nxt_count;
                        if (frame_end) begin
                            // Register sums/spans from the final extents, including the last pixel.
                            sum_x  <= {1'b0, nxt_min_x} + {1'b0, nxt_max_x};
                            sum_y  <= {1'b0, nxt_min_y} + {1'b0, nxt_max_y};
                            span_x <= nxt_max_x - nxt_min_x;
                            span_y <= nxt_max_y - nxt_min_y;
                            state  <= FINAL;
                        end
                    end
                    FINAL: begin
                        if (count >= MIN_COUNT) begin
                            t_x      <= sum_x[11:1];
                            t_y      <= sum_y[10:1];
                            t_width  <= span_x + 11'd1;
                            t_height <= {1'b0, span_y} + 11'd1;
                            found    <= 1'b1;
                        end else begin
                            found    <= 1'b0;
                        end
                        result_valid <= 1'b1;
                        state        <= PUBLISH;
                    end
                    PUBLISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_target_extent_tracker.sv
// Randomised and directed bench for target_extent_tracker; two instances
// (MIN_PIXELS=16 and MIN_PIXELS=1) share one stimulus stream.
module tb_target_extent_tracker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_match = 1'b0;
    logic [10:0] pix_x = '0;
    logic [9:0]  pix_y = '0;

    logic [10:0] t_x [2];
    logic [9:0]  t_y [2];
    logic [10:0] t_width [2];
    logic [10:0] t_height [2];
    logic        found [2];
    logic        result_valid [2];
    logic [1:0]  fsm_state [2];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    target_extent_tracker #(.MIN_PIXELS(16)) u_dut_def (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_match(pix_match),
        .t_x(t_x[0]), .t_y(t_y[0]), .t_width(t_width[0]), .t_height(t_height[0]),
        .found(found[0]), .result_valid(result_valid[0]), .fsm_state(fsm_state[0])
    );

    target_extent_tracker #(.MIN_PIXELS(1)) u_dut_one (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_match(pix_match),
        .t_x(t_x[1]), .t_y(t_y[1]), .t_width(t_width[1]), .t_height(t_height[1]),
        .found(found[1]), .result_valid(result_valid[1]), .fsm_state(fsm_state[1])
    );

    // Reference model: matched pixels of the open frame, published expectations.
    int          px_q[$];
    int          py_q[$];
    bit          in_frame = 1'b0;
    int          thr [2] = '{16, 1};
    logic [10:0] e_tx [2];
    logic [9:0]  e_ty [2];
    logic [10:0] e_tw [2];
    logic [10:0] e_th [2];
    logic        e_found [2];
    int          exp_pulses [2] = '{0, 0};
    int          pulses [2] = '{0, 0};

    always @(negedge clk) begin
        if (result_valid[0] === 1'b1) pulses[0]++;
        if (result_valid[1] === 1'b1) pulses[1]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_outputs();
        for (int i = 0; i < 2; i++) begin
            e_tx[i] = '0; e_ty[i] = '0; e_tw[i] = '0; e_th[i] = '0; e_found[i] = 1'b0;
        end
    endtask

    task automatic model_accept(input logic v, input logic m, input logic [10:0] x, input logic [9:0] y);
        if (in_frame && v && m) begin
            px_q.push_back(int'(x));
            py_q.push_back(int'(y));
        end
    endtask

    task automatic model_publish();
        int mnx = 2047, mxx = 0, mny = 1023, mxy = 0;
        foreach (px_q[k]) begin
            if (px_q[k] < mnx) mnx = px_q[k];
            if (px_q[k] > mxx) mxx = px_q[k];
            if (py_q[k] < mny) mny = py_q[k];
            if (py_q[k] > mxy) mxy = py_q[k];
        end
        for (int i = 0; i < 2; i++) begin
            if (px_q.size() >= thr[i]) begin
                e_tx[i]    = 11'((mnx + mxx) / 2);
                e_ty[i]    = 10'((mny + mxy) / 2);
                e_tw[i]    = 11'(mxx - mnx + 1);
                e_th[i]    = 11'(mxy - mny + 1);
                e_found[i] = 1'b1;
            end else begin
                e_found[i] = 1'b0;
            end
            exp_pulses[i]++;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_u%0d_t_x", tag, i), 32'(t_x[i]), 32'(e_tx[i]));
            check($sformatf("%s_u%0d_t_y", tag, i), 32'(t_y[i]), 32'(e_ty[i]));
            check($sformatf("%s_u%0d_t_width", tag, i), 32'(t_width[i]), 32'(e_tw[i]));
            check($sformatf("%s_u%0d_t_height", tag, i), 32'(t_height[i]), 32'(e_th[i]));
            check($sformatf("%s_u%0d_found", tag, i), 32'(found[i]), 32'(e_found[i]));
        end
    endtask

    task automatic check_pulses(input string tag);
        for (int i = 0; i < 2; i++)
            check($sformatf("%s_u%0d_pulses", tag, i), 32'(pulses[i]), 32'(exp_pulses[i]));
    endtask

    task automatic drive(input logic fs, input logic fe, input logic v, input logic m,
                         input logic [10:0] x, input logic [9:0] y);
        frame_start = fs; frame_end = fe; pix_valid = v; pix_match = m; pix_x = x; pix_y = y;
    endtask

    task automatic begin_frame(input logic v, input logic m, input logic [10:0] x, input logic [9:0] y);
        drive(1'b1, 1'b0, v, m, x, y);
        px_q.delete();
        py_q.delete();
        in_frame = 1'b1;
        model_accept(v, m, x, y);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic send_pixel(input logic v, input logic m, input logic [10:0] x, input logic [9:0] y);
        drive(1'b0, 1'b0, v, m, x, y);
        model_accept(v, m, x, y);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Drives frame_end (optionally with a last pixel) and checks the pulse lands exactly two cycles later.
    task automatic end_frame(input string tag, input logic v, input logic m,
                             input logic [10:0] x, input logic [9:0] y);
        bit was_open = in_frame;
        drive(1'b0, 1'b1, v, m, x, y);
        model_accept(v, m, x, y);
        in_frame = 1'b0;
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        if (!was_open) begin
            for (int k = 0; k < 4; k++) tick();
            check_pulses({tag, "_no_pulse"});
            check({tag, "_rv_low"}, 32'(result_valid[0]), 32'd0);
        end else begin
            check({tag, "_rv_plus1"}, 32'({result_valid[1], result_valid[0]}), 32'd0);
            model_publish();
            tick();
            check({tag, "_rv_plus2"}, 32'({result_valid[1], result_valid[0]}), 32'd3);
            check_outputs({tag, "_pub"});
            tick();
            check({tag, "_rv_plus3"}, 32'({result_valid[1], result_valid[0]}), 32'd0);
            check_outputs({tag, "_hold"});
            check_pulses(tag);
        end
    endtask

    initial begin
        // Reset state
        model_clear_outputs();
        tick();
        tick();
        check_outputs("reset");
        check("reset_state", 32'(fsm_state[0]), 32'd0);
        check("reset_rv", 32'(result_valid[0]), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single match at (100,50)
        begin_frame(1'b0, 1'b0, '0, '0);
        send_pixel(1'b1, 1'b1, 11'd100, 10'd50);
        send_pixel(1'b1, 1'b0, 11'd900, 10'd900);
        end_frame("single", 1'b0, 1'b0, '0, '0);

        // 20x10 block; last pixel coincides with frame_end
        begin_frame(1'b1, 1'b1, 11'd200, 10'd100);
        for (int yy = 100; yy < 110; yy++)
            for (int xx = 200; xx < 220; xx++)
                if (!(xx == 200 && yy == 100) && !(xx == 219 && yy == 109))
                    send_pixel(1'b1, 1'b1, 11'(xx), 10'(yy));
        end_frame("block", 1'b1, 1'b1, 11'd219, 10'd109);
        check("block_t_x_const", 32'(t_x[0]), 32'd209);
        check("block_t_y_const", 32'(t_y[0]), 32'd104);

        // Too few matches: default instance keeps previous box
        begin_frame(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 5; k++) send_pixel(1'b1, 1'b1, 11'(700 + k), 10'(30 + k));
        end_frame("few", 1'b0, 1'b0, '0, '0);

        // Wide extent
        begin_frame(1'b1, 1'b1, 11'd0, 10'd0);
        send_pixel(1'b1, 1'b1, 11'd1023, 10'd524);
        for (int k = 0; k < 14; k++) send_pixel(1'b1, 1'b1, 11'(400 + 7 * k), 10'(100 + 5 * k));
        end_frame("wide", 1'b0, 1'b0, '0, '0);
        check("wide_width_const", 32'(t_width[0]), 32'd1024);
        check("wide_height_const", 32'(t_height[0]), 32'd525);

        // Restart mid-frame discards earlier matches
        begin_frame(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 20; k++) send_pixel(1'b1, 1'b1, 11'd10, 10'(k));
        begin_frame(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 20; k++) send_pixel(1'b1, 1'b1, 11'(500 + k), 10'd300);
        end_frame("restart", 1'b0, 1'b0, '0, '0);
        check("restart_width_const", 32'(t_width[0]), 32'd20);

        // frame_start in FINAL aborts that frame's publication
        begin_frame(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 20; k++) send_pixel(1'b1, 1'b1, 11'(1500 + k), 10'd800);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        in_frame = 1'b0;
        tick();
        begin_frame(1'b1, 1'b1, 11'd40, 10'd40);
        for (int k = 0; k < 17; k++) send_pixel(1'b1, 1'b1, 11'(41 + k), 10'(41 + 2 * k));
        end_frame("final_abort", 1'b0, 1'b0, '0, '0);

        // Randomised frames
        for (int f = 0; f < 30; f++) begin
            int n = $urandom_range(0, 40);
            int bx = $urandom_range(0, 1900);
            int by = $urandom_range(0, 900);
            for (int k = 0; k < 2; k++)
                send_pixel(1'($urandom_range(0, 1)), 1'b1, 11'($urandom_range(0, 2047)), 10'($urandom_range(0, 1023)));
            begin_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        11'(bx + $urandom_range(0, 147)), 10'(by + $urandom_range(0, 123)));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 40) == 0) begin_frame(1'b0, 1'b0, '0, '0);
                send_pixel(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) < 3),
                           11'(bx + $urandom_range(0, 147)), 10'(by + $urandom_range(0, 123)));
            end
            end_frame($sformatf("rand%0d", f), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      11'(bx + $urandom_range(0, 147)), 10'(by + $urandom_range(0, 123)));
            if ($urandom_range(0, 5) == 0) end_frame($sformatf("stray%0d", f), 1'b0, 1'b0, '0, '0);
        end

        // Asynchronous reset mid-frame, then frame_end with no frame_start
        begin_frame(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 6; k++) send_pixel(1'b1, 1'b1, 11'(300 + k), 10'(200 + k));
        #3;
        reset_n = 1'b0;
        #1;
        model_clear_outputs();
        in_frame = 1'b0;
        px_q.delete();
        py_q.delete();
        check_outputs("async_reset");
        check("async_reset_state", 32'(fsm_state[0]), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        end_frame("post_reset", 1'b1, 1'b1, 11'd5, 10'd5);
        check_outputs("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
